csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
- Sequences every writeback-stage event that touches the CSR file.
  - Arbitrates the single CSR write port between ordinary csrwr/csrxchg retirements and trap/ertn commits.
  - Recognises pending interrupts against the retiring instruction.
  - Drives a pipeline flush and a valid/ready redirect to fetch.
- Sits between the WB stage, the CSR file and the IF stage.

Parameters:
INT_ECODE, 6'd0, ecode reported for an interrupt trap
INT_BLOCK_CYCLES, 1, cycles interrupt recognition is masked after a CSR write to CRMD/ECFG/ESTAT/TICLR
CNT_W, 16, width of trap counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
wb_valid  in  1  WB holds a retiring instruction
wb_pc  in  32  PC of WB instruction
wb_ex  in  1  WB instruction carries an exception
wb_ecode  in  6  exception code
wb_esubcode  in  9  exception subcode
wb_vaddr  in  32  faulting data address
wb_ertn  in  1  WB instruction is ertn
wb_csr_we  in  1  WB instruction writes a CSR
wb_csr_num  in  14  CSR number
wb_csr_wmask  in  32  write mask
wb_csr_wvalue  in  32  write data
wb_ready  out  1  WB may retire this cycle
has_int  in  1  CSR file: enabled interrupt pending
ex_entry  in  32  CSR file: trap entry
era  in  32  CSR file: return address
csr_we  out  1  CSR write enable
csr_num  out  14  CSR number (write)
csr_wmask  out  32  CSR write mask
csr_wvalue  out  32  CSR write data
csr_wb_ex  out  1  trap commit pulse to CSR
csr_ertn_flush  out  1  ertn commit pulse to CSR
csr_pc  out  32  trap PC to CSR
csr_ecode  out  6  trap ecode to CSR
csr_esubcode  out  9  trap subcode to CSR
csr_vaddr  out  32  trap vaddr to CSR
flush  out  1  kill all younger pipeline stages
redirect_valid  out  1  new fetch PC offered
redirect_pc  out  32  new fetch PC
redirect_ready  in  1  fetch accepts redirect
trap_cnt  out  CNT_W  count of committed traps (exceptions and interrupts)

Behaviour:
- Interface: one clock, clk. Reset, reset, is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - Zero: csr_wb_ex, csr_ertn_flush, flush, redirect_valid, redirect_pc, trap_cnt, the masking counter and the latched trap fields.
  - wb_ready is 0 while reset is high.
  - Reset mid-sequence aborts the sequence with no further pulses.
- FSM: IDLE, COMMIT, REDIRECT.
- int_take = has_int & wb_valid & (blk_cnt==0).
- event = wb_valid & (wb_ex | int_take | wb_ertn).
- Priority: wb_ex > int_take > wb_ertn.
- IDLE:
  - wb_ready=1.
  - If no event: csr_we = wb_valid & wb_csr_we, combinationally, with num/mask/value passed through.
  - On event:
    - csr_we=0 that cycle.
    - Latch pc/ecode/esubcode/vaddr and kind (EX or ERTN).
    - Go to COMMIT.
  - Interrupt latch values: pc=wb_pc, ecode=INT_ECODE, esubcode=0, vaddr=0. The interrupted instruction does not retire its effects.
- COMMIT (exactly 1 cycle):
  - Pulse csr_wb_ex (EX) or csr_ertn_flush (ERTN) from the latched fields.
  - flush=1, wb_ready=0, csr_we=0.
  - Latch redirect_pc = ex_entry (EX) or era (ERTN).
  - trap_cnt += 1 on EX; wraps modulo 2^CNT_W.
  - Go to REDIRECT.
- REDIRECT:
  - flush=1, redirect_valid=1, wb_ready=0, csr_we=0.
  - redirect_pc is held stable until the handshake.
  - redirect_valid & redirect_ready leads to IDLE; the next cycle has flush=0.
  - redirect_ready may already be high on the first REDIRECT cycle, giving a 1-cycle stay.
- Latency: event in IDLE at cycle N → commit pulse at N+1 → redirect_valid from N+2.
- Interrupt masking:
  - A retired csr_we to CSR 0x0, 0x4, 0x5 or 0x44 loads blk_cnt=INT_BLOCK_CYCLES.
  - blk_cnt decrements to 0 each cycle. A load takes precedence over the decrement.
  - Exception and ertn commits clear blk_cnt.
- wb_ex with wb_csr_we: the write is suppressed.
- wb_ertn with has_int and blk_cnt==0: the interrupt wins; era = ertn PC.
- has_int while not IDLE: ignored. It is re-evaluated against the first instruction in IDLE.

Decomposition:
- Shared package csr_pkg:
  - CSR numbers: CRMD 0, PRMD 1, ECFG 4, ESTAT 5, ERA 6, BADV 7, EENTRY 12, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
  - Ecode constants: INT 0x0, ADE 0x8, ALE 0x9, SYS 0xB.
  - FSM state encoding.
- Single module; no sub-module is warranted.

Test Plan:
- csrwr: wb_valid=1, wb_csr_we=1, num=0x30, mask=FFFFFFFF, value=0x12345678, no event → same-cycle csr_we=1 with those values; wb_ready=1; no flush.
- Syscall: wb_ex=1, ecode=0xB, wb_pc=0x1c000100, ex_entry=0x1c008000 → next cycle csr_wb_ex=1 (pc 0x1c000100, ecode 0xB) for 1 cycle; then redirect_valid=1 with redirect_pc=0x1c008000; trap_cnt=1.
- Back-pressure: hold redirect_ready=0 for 5 cycles → redirect_valid/flush/redirect_pc stable and wb_ready=0 throughout; ready=1 → IDLE next cycle.
- ertn with era=0x1c000204, has_int=0 → csr_ertn_flush pulse, redirect_pc=0x1c000204, trap_cnt unchanged.
- Masking: csrwr to ECFG (0x4) at cycle N, has_int=1 from N+1 → no trap at N+1 (INT_BLOCK_CYCLES=1); trap with ecode 0 at N+2 on the next valid instruction.
- Priority and reset: wb_ex=1 (ecode 0x8) with has_int=1 → ecode 0x8 committed. Separately, reset during REDIRECT → next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR numbering, exception codes and trap-sequencer encodings used by
// the writeback-stage trap controller.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_REDIRECT
  } trap_state_e;

  typedef enum logic {
    KIND_EX,
    KIND_ERTN
  } trap_kind_e;

  // Writes to these CSRs can change which interrupts are enabled or pending.
  function automatic logic masks_int(input logic [13:0] num);
    return (num == CSR_CRMD) || (num == CSR_ECFG) ||
           (num == CSR_ESTAT) || (num == CSR_TICLR);
  endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// Writeback-stage CSR sequencer: arbitrates the CSR write port, recognises
// interrupts and runs the trap/ertn commit, flush and fetch-redirect sequence.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [5:0] INT_ECODE        = 6'd0,
  parameter int         INT_BLOCK_CYCLES = 1,
  parameter int         CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic             wb_ex,
  input  logic [5:0]       wb_ecode,
  input  logic [8:0]       wb_esubcode,
  input  logic [31:0]      wb_vaddr,
  input  logic             wb_ertn,
  input  logic             wb_csr_we,
  input  logic [13:0]      wb_csr_num,
  input  logic [31:0]      wb_csr_wmask,
  input  logic [31:0]      wb_csr_wvalue,
  output logic             wb_ready,
  input  logic             has_int,
  input  logic [31:0]      ex_entry,
  input  logic [31:0]      era,
  output logic             csr_we,
  output logic [13:0]      csr_num,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  output logic             csr_wb_ex,
  output logic             csr_ertn_flush,
  output logic [31:0]      csr_pc,
  output logic [5:0]       csr_ecode,
  output logic [8:0]       csr_esubcode,
  output logic [31:0]      csr_vaddr,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic [CNT_W-1:0] trap_cnt
);

  localparam int BLK_W = (INT_BLOCK_CYCLES > 1) ? $clog2(INT_BLOCK_CYCLES + 1) : 1;
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(INT_BLOCK_CYCLES);

  trap_state_e      state;
  trap_kind_e       kind;
  logic [BLK_W-1:0] blk_cnt;

  logic in_idle;
  logic int_take;
  logic take_ex;
  logic trap_event;

  assign in_idle    = (state == ST_IDLE);
  assign int_take   = has_int & wb_valid & (blk_cnt == '0);
  assign take_ex    = wb_ex | int_take;
  assign trap_event = wb_valid & (wb_ex | int_take | wb_ertn);

  // An instruction that traps or is interrupted must not retire its CSR write.
  assign wb_ready   = in_idle & ~reset;
  assign csr_we     = in_idle & ~reset & wb_valid & wb_csr_we & ~trap_event;
  assign csr_num    = wb_csr_num;
  assign csr_wmask  = wb_csr_wmask;
  assign csr_wvalue = wb_csr_wvalue;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      kind           <= KIND_EX;
      csr_wb_ex      <= 1'b0;
      csr_ertn_flush <= 1'b0;
      csr_pc         <= '0;
      csr_ecode      <= '0;
      csr_esubcode   <= '0;
      csr_vaddr      <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_cnt       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (trap_event) begin
            kind           <= take_ex ? KIND_EX : KIND_ERTN;
            csr_wb_ex      <= take_ex;
            csr_ertn_flush <= ~take_ex;
            csr_pc         <= wb_pc;
            flush          <= 1'b1;
            state          <= ST_COMMIT;
            if (!wb_ex && int_take) begin
              csr_ecode    <= INT_ECODE;
              csr_esubcode <= '0;
              csr_vaddr    <= '0;
            end else begin
              csr_ecode    <= wb_ecode;
              csr_esubcode <= wb_esubcode;
              csr_vaddr    <= wb_vaddr;
            end
          end
        end
        ST_COMMIT: begin
          csr_wb_ex      <= 1'b0;
          csr_ertn_flush <= 1'b0;
          redirect_valid <= 1'b1;
          redirect_pc    <= (kind == KIND_EX) ? ex_entry : era;
          if (kind == KIND_EX) trap_cnt <= trap_cnt + CNT_W'(1);
          state          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Interrupt recognition is held off briefly after writes that may change
  // the pending/enabled interrupt set, so the CSR file settles first.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt <= '0;
    end else if (state == ST_COMMIT) begin
      blk_cnt <= '0;
    end else if (csr_we && masks_int(wb_csr_num)) begin
      blk_cnt <= BLK_LOAD;
    end else if (blk_cnt != '0) begin
      blk_cnt <= blk_cnt - BLK_W'(1);
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-numbered transaction model.
module tb_csr_trap_ctrl;

  localparam int INT_BLOCK_CYCLES = 1;
  localparam int CNT_W            = 16;

  logic             clk;
  logic             reset;
  logic             wb_valid;
  logic [31:0]      wb_pc;
  logic             wb_ex;
  logic [5:0]       wb_ecode;
  logic [8:0]       wb_esubcode;
  logic [31:0]      wb_vaddr;
  logic             wb_ertn;
  logic             wb_csr_we;
  logic [13:0]      wb_csr_num;
  logic [31:0]      wb_csr_wmask;
  logic [31:0]      wb_csr_wvalue;
  logic             wb_ready;
  logic             has_int;
  logic [31:0]      ex_entry;
  logic [31:0]      era;
  logic             csr_we;
  logic [13:0]      csr_num;
  logic [31:0]      csr_wmask;
  logic [31:0]      csr_wvalue;
  logic             csr_wb_ex;
  logic             csr_ertn_flush;
  logic [31:0]      csr_pc;
  logic [5:0]       csr_ecode;
  logic [8:0]       csr_esubcode;
  logic [31:0]      csr_vaddr;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ready;
  logic [CNT_W-1:0] trap_cnt;

  csr_trap_ctrl #(
    .INT_ECODE       (6'd0),
    .INT_BLOCK_CYCLES(INT_BLOCK_CYCLES),
    .CNT_W           (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_pc         (wb_pc),
    .wb_ex         (wb_ex),
    .wb_ecode      (wb_ecode),
    .wb_esubcode   (wb_esubcode),
    .wb_vaddr      (wb_vaddr),
    .wb_ertn       (wb_ertn),
    .wb_csr_we     (wb_csr_we),
    .wb_csr_num    (wb_csr_num),
    .wb_csr_wmask  (wb_csr_wmask),
    .wb_csr_wvalue (wb_csr_wvalue),
    .wb_ready      (wb_ready),
    .has_int       (has_int),
    .ex_entry      (ex_entry),
    .era           (era),
    .csr_we        (csr_we),
    .csr_num       (csr_num),
    .csr_wmask     (csr_wmask),
    .csr_wvalue    (csr_wvalue),
    .csr_wb_ex     (csr_wb_ex),
    .csr_ertn_flush(csr_ertn_flush),
    .csr_pc        (csr_pc),
    .csr_ecode     (csr_ecode),
    .csr_esubcode  (csr_esubcode),
    .csr_vaddr     (csr_vaddr),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .redirect_ready(redirect_ready),
    .trap_cnt      (trap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction model: a sequence is identified by the cycle its event was
  // seen; commit is the next cycle, the redirect offer runs from two after.
  int          cyc          = 0;
  bit          m_busy       = 0;
  int          m_ev_cyc     = 0;
  bit          m_is_trap    = 0;
  logic [31:0] m_pc         = '0;
  logic [5:0]  m_ecode      = '0;
  logic [8:0]  m_esub       = '0;
  logic [31:0] m_vaddr      = '0;
  logic [31:0] m_redir_pc   = '0;
  int          m_traps      = 0;
  int          m_last_mask  = -100;

  bit e_ev, e_int, e_we, e_commit, e_redir;

  function automatic bit is_mask_csr(input logic [13:0] n);
    return n == 14'h0 || n == 14'h4 || n == 14'h5 || n == 14'h44;
  endfunction

  task automatic compute_expect();
    e_int    = !m_busy && has_int && wb_valid && ((cyc - m_last_mask) > INT_BLOCK_CYCLES);
    e_ev     = !m_busy && wb_valid && (wb_ex || e_int || wb_ertn);
    e_we     = !m_busy && !reset && wb_valid && wb_csr_we && !e_ev;
    e_commit = m_busy && (cyc == m_ev_cyc + 1);
    e_redir  = m_busy && (cyc >= m_ev_cyc + 2);
  endtask

  task automatic sample();
    #4;
    compute_expect();
    check("wb_ready", 32'(wb_ready), 32'(!m_busy && !reset));
    check("csr_we", 32'(csr_we), 32'(e_we));
    if (e_we) begin
      check("csr_num", 32'(csr_num), 32'(wb_csr_num));
      check("csr_wmask", csr_wmask, wb_csr_wmask);
      check("csr_wvalue", csr_wvalue, wb_csr_wvalue);
    end
    check("csr_wb_ex", 32'(csr_wb_ex), 32'(e_commit && m_is_trap));
    check("csr_ertn_flush", 32'(csr_ertn_flush), 32'(e_commit && !m_is_trap));
    if (e_commit && m_is_trap) begin
      check("csr_pc", csr_pc, m_pc);
      check("csr_ecode", 32'(csr_ecode), 32'(m_ecode));
      check("csr_esubcode", 32'(csr_esubcode), 32'(m_esub));
      check("csr_vaddr", csr_vaddr, m_vaddr);
    end
    check("flush", 32'(flush), 32'(e_commit || e_redir));
    check("redirect_valid", 32'(redirect_valid), 32'(e_redir));
    check("redirect_pc", redirect_pc, m_redir_pc);
    check("trap_cnt", 32'(trap_cnt), 32'(m_traps % (1 << CNT_W)));
  endtask

  task automatic advance();
    compute_expect();
    @(posedge clk);
    if (reset) begin
      m_busy      = 0;
      m_traps     = 0;
      m_redir_pc  = '0;
      m_last_mask = -100;
    end else if (!m_busy) begin
      if (e_ev) begin
        m_busy    = 1;
        m_ev_cyc  = cyc;
        m_is_trap = wb_ex || e_int;
        m_pc      = wb_pc;
        m_ecode   = wb_ex ? wb_ecode : 6'd0;
        m_esub    = wb_ex ? wb_esubcode : 9'd0;
        m_vaddr   = wb_ex ? wb_vaddr : 32'd0;
      end else if (e_we && is_mask_csr(wb_csr_num)) begin
        m_last_mask = cyc;
      end
    end else if (e_commit) begin
      m_redir_pc  = m_is_trap ? ex_entry : era;
      m_traps     = m_traps + (m_is_trap ? 1 : 0);
      m_last_mask = -100;
    end else if (e_redir && redirect_ready) begin
      m_busy = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic quiet();
    reset = 0; wb_valid = 0; wb_pc = '0; wb_ex = 0; wb_ecode = '0;
    wb_esubcode = '0; wb_vaddr = '0; wb_ertn = 0; wb_csr_we = 0;
    wb_csr_num = '0; wb_csr_wmask = '0; wb_csr_wvalue = '0; has_int = 0;
  endtask

  task automatic drain();
    redirect_ready = 1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    quiet();
    ex_entry = 32'h1c008000;
    era = 32'h1c000204;
    redirect_ready = 1;
    reset = 1;
    @(posedge clk);
    #1;

    // Reset state.
    tick();
    sample();
    check("rst_wb_ready", 32'(wb_ready), 32'd0);
    advance();
    reset = 0;
    sample();
    check("rst_trap_cnt", 32'(trap_cnt), 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    advance();

    // Plain csrwr retires in the same cycle.
    wb_valid = 1; wb_csr_we = 1; wb_csr_num = 14'h30;
    wb_csr_wmask = 32'hffffffff; wb_csr_wvalue = 32'h12345678;
    sample();
    check("csrwr_we", 32'(csr_we), 32'd1);
    check("csrwr_value", csr_wvalue, 32'h12345678);
    advance();
    quiet();

    // Syscall with five cycles of redirect back-pressure.
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'hb; wb_pc = 32'h1c000100;
    wb_csr_we = 1; wb_csr_num = 14'h30;
    redirect_ready = 0;
    sample();
    check("sys_we_suppressed", 32'(csr_we), 32'd0);
    advance();
    quiet();
    sample();
    check("sys_pulse", 32'(csr_wb_ex), 32'd1);
    check("sys_pc", csr_pc, 32'h1c000100);
    check("sys_ecode", 32'(csr_ecode), 32'hb);
    advance();
    for (int i = 0; i < 5; i++) begin
      sample();
      check("bp_redirect_pc", redirect_pc, 32'h1c008000);
      check("bp_valid", 32'(redirect_valid), 32'd1);
      check("bp_trap_cnt", 32'(trap_cnt), 32'd1);
      advance();
    end
    redirect_ready = 1;
    tick();
    sample();
    check("bp_idle_flush", 32'(flush), 32'd0);
    check("bp_idle_ready", 32'(wb_ready), 32'd1);
    advance();

    // ertn returns to era without counting a trap.
    wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1c000300;
    tick();
    quiet();
    sample();
    check("ertn_pulse", 32'(csr_ertn_flush), 32'd1);
    advance();
    sample();
    check("ertn_redirect_pc", redirect_pc, 32'h1c000204);
    check("ertn_trap_cnt", 32'(trap_cnt), 32'd1);
    advance();
    tick();

    // Interrupt masked for one cycle after an ECFG write.
    wb_valid = 1; wb_csr_we = 1; wb_csr_num = 14'h4; wb_csr_wvalue = 32'h1;
    tick();
    quiet();
    wb_valid = 1; has_int = 1; wb_pc = 32'h1c000400;
    tick();
    wb_pc = 32'h1c000404;
    sample();
    check("mask_no_trap", 32'(csr_wb_ex), 32'd0);
    advance();
    quiet();
    sample();
    check("mask_int_pulse", 32'(csr_wb_ex), 32'd1);
    check("mask_int_ecode", 32'(csr_ecode), 32'd0);
    check("mask_int_pc", csr_pc, 32'h1c000404);
    advance();
    drain();

    // Exception outranks a pending interrupt.
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h8; has_int = 1; wb_pc = 32'h1c000500;
    tick();
    quiet();
    sample();
    check("prio_ecode", 32'(csr_ecode), 32'h8);
    advance();
    drain();

    // Reset while the redirect is being offered.
    wb_valid = 1; wb_ex = 1; wb_ecode = 6'h9;
    redirect_ready = 0;
    tick();
    quiet();
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    sample();
    check("rst_mid_flush", 32'(flush), 32'd0);
    check("rst_mid_valid", 32'(redirect_valid), 32'd0);
    check("rst_mid_pc", redirect_pc, 32'd0);
    check("rst_mid_cnt", 32'(trap_cnt), 32'd0);
    advance();
    redirect_ready = 1;

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      wb_valid       = ($urandom_range(0, 9) < 7);
      wb_pc          = {$urandom_range(0, 32'hffff), 2'b00} | 32'h1c000000;
      wb_ex          = ($urandom_range(0, 9) == 0);
      wb_ecode       = 6'($urandom_range(0, 63));
      wb_esubcode    = 9'($urandom_range(0, 511));
      wb_vaddr       = $urandom;
      wb_ertn        = ($urandom_range(0, 11) == 0);
      wb_csr_we      = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 5))
        0: wb_csr_num = 14'h0;
        1: wb_csr_num = 14'h4;
        2: wb_csr_num = 14'h5;
        3: wb_csr_num = 14'h44;
        4: wb_csr_num = 14'h6;
        default: wb_csr_num = 14'($urandom_range(0, 16383));
      endcase
      wb_csr_wmask   = $urandom;
      wb_csr_wvalue  = $urandom;
      has_int        = ($urandom_range(0, 6) == 0);
      ex_entry       = $urandom;
      era            = $urandom;
      redirect_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
